// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : capture_sequencer
// Brief    : Single triggered-capture sequencer for the ADC sample FIFO.
//            It runs pre-trigger fill, a rolling window, threshold trigger,
//            post-trigger collection and a word-by-word SPI drain.
// Revision : 1.0  initial release
// ============================================================================
module capture_sequencer #(
  parameter int PRETRIG_DEPTH      = 10,
  parameter int THRESHOLD          = 32,
  parameter int VALID_COUNT_NEEDED = 4,
  parameter int POSTTRIG_SAMPLES   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic        spi_done,
  output logic [15:0] fifo_wdata,
  output logic        fifo_write,
  output logic        fifo_read,
  output logic        fifo_clear,
  output logic        data_avail,
  output logic        capture_done,
  output logic        overflow,
  output logic [2:0]  state_dbg
);

  localparam int c_pre_w  = $clog2(PRETRIG_DEPTH + 1);
  localparam int c_hit_w  = $clog2(VALID_COUNT_NEEDED + 1);
  localparam int c_post_w = $clog2(POSTTRIG_SAMPLES + 1);

  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PRETRIG_DEPTH - 1);
  localparam logic [c_hit_w-1:0]  c_hit_last  = c_hit_w'(VALID_COUNT_NEEDED - 1);
  localparam logic [c_post_w-1:0] c_post_last = c_post_w'(POSTTRIG_SAMPLES - 1);
  localparam logic [16:0]         c_thresh    = 17'(THRESHOLD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFILL  = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    SETTLE   = 3'd4,
    DRAIN    = 3'd5,
    WAIT_SPI = 3'd6
  } state_t;

  state_t                r_state;
  logic [c_pre_w-1:0]    r_pre_cnt;
  logic [c_hit_w-1:0]    r_hit_cnt;
  logic [c_post_w-1:0]   r_post_cnt;
  logic [15:0]           w_mag;
  logic                  w_qual;

  // Most-negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    w_mag = sample_data;
    if (sample_data[15]) begin
      w_mag = (sample_data == 16'h8000) ? 16'h7fff : (~sample_data + 16'd1);
    end
  end

  assign w_qual    = ({1'b0, w_mag} >= c_thresh);
  assign state_dbg = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pre_cnt    <= '0;
      r_hit_cnt    <= '0;
      r_post_cnt   <= '0;
      fifo_wdata   <= '0;
      fifo_write   <= 1'b0;
      fifo_read    <= 1'b0;
      fifo_clear   <= 1'b0;
      data_avail   <= 1'b0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      fifo_write   <= 1'b0;
      fifo_read    <= 1'b0;
      fifo_clear   <= 1'b0;
      capture_done <= 1'b0;
      case (r_state)
        IDLE: begin
          data_avail <= 1'b0;
          if (enable) begin
            fifo_clear <= 1'b1;
            r_pre_cnt  <= '0;
            r_hit_cnt  <= '0;
            r_post_cnt <= '0;
            overflow   <= 1'b0;
            r_state    <= PREFILL;
          end
        end
        PREFILL: begin
          if (sample_valid) begin
            fifo_write <= 1'b1;
            fifo_wdata <= sample_data;
            r_pre_cnt  <= r_pre_cnt + 1'b1;
            if (r_pre_cnt == c_pre_last) r_state <= ARMED;
          end
          if (!enable) r_state <= IDLE;
        end
        ARMED: begin
          // Pop and push together keeps the window at a constant depth.
          if (sample_valid) begin
            fifo_read  <= 1'b1;
            fifo_write <= 1'b1;
            fifo_wdata <= sample_data;
            if (!w_qual) begin
              r_hit_cnt <= '0;
            end else if (r_hit_cnt == c_hit_last) begin
              r_hit_cnt  <= '0;
              r_post_cnt <= '0;
              r_state    <= POST;
            end else begin
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end
          if (!enable) r_state <= IDLE;
        end
        POST: begin
          if (sample_valid) begin
            if (fifo_full) begin
              overflow <= 1'b1;
              r_state  <= SETTLE;
            end else begin
              fifo_write <= 1'b1;
              fifo_wdata <= sample_data;
              r_post_cnt <= r_post_cnt + 1'b1;
              if (r_post_cnt == c_post_last) r_state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          data_avail <= 1'b1;
          r_state    <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            capture_done <= 1'b1;
            data_avail   <= 1'b0;
            r_state      <= IDLE;
          end else begin
            fifo_read <= 1'b1;
            r_state   <= WAIT_SPI;
          end
        end
        WAIT_SPI: begin
          if (spi_done) r_state <= DRAIN;
        end
        default: begin
          data_avail <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// Bench for capture_sequencer: emulated FIFO and SPI host, directed scenarios
// plus randomized captures scored against a sample-stream reference model.
module tb_capture_sequencer;

  localparam int c_depth = 10;
  localparam int c_thr   = 32;
  localparam int c_valid = 4;
  localparam int c_post  = 20;
  localparam int c_cap   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, sample_valid, spi_done, force_full;
  logic [15:0] sample_data;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_wdata;
  logic        fifo_write, fifo_read, fifo_clear, data_avail, capture_done, overflow;
  logic [2:0]  state_dbg;

  logic        s_rst, s_enable;
  logic [15:0] s_wdata;
  logic        s_write, s_read, s_clear, s_avail, s_done, s_ovf;
  logic [2:0]  s_state;

  int total = 0;
  int bad   = 0;

  capture_sequencer u_dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .spi_done(spi_done), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
    .fifo_read(fifo_read), .fifo_clear(fifo_clear), .data_avail(data_avail),
    .capture_done(capture_done), .overflow(overflow), .state_dbg(state_dbg)
  );

  // Full-scale threshold instance for the saturation boundary.
  capture_sequencer #(
    .PRETRIG_DEPTH(2), .THRESHOLD(32767), .VALID_COUNT_NEEDED(4), .POSTTRIG_SAMPLES(3)
  ) u_sat (
    .clk(clk), .rst(s_rst), .enable(s_enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(1'b0), .fifo_empty(1'b1),
    .spi_done(spi_done), .fifo_wdata(s_wdata), .fifo_write(s_write),
    .fifo_read(s_read), .fifo_clear(s_clear), .data_avail(s_avail),
    .capture_done(s_done), .overflow(s_ovf), .state_dbg(s_state)
  );

  // Emulated FIFO and strobe bookkeeping.
  logic [15:0] q[$];
  logic [15:0] drained[$];
  int fsize = 0;
  int n_wr = 0, n_roll = 0, n_rd = 0, n_clr = 0, n_done = 0, n_spi = 0;

  assign fifo_full  = force_full || (fsize >= c_cap);
  assign fifo_empty = (fsize == 0);

  always @(posedge clk) begin
    if (fifo_clear) begin
      q.delete();
      n_clr++;
    end else begin
      if (fifo_read && q.size() > 0) begin
        if (!fifo_write) begin
          drained.push_back(q[0]);
          n_rd++;
        end else begin
          n_roll++;
        end
        void'(q.pop_front());
      end
      if (fifo_write && q.size() < c_cap) begin
        q.push_back(fifo_wdata);
        if (!fifo_read) n_wr++;
      end
    end
    if (capture_done) n_done++;
    if (spi_done) n_spi++;
    fsize <= q.size();
  end

  // SPI host: finishes each word a few cycles after the read strobe.
  int spi_wait = 0;
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (state_dbg == 3'd6) begin
      if (spi_wait == 0) spi_wait = $urandom_range(2, 5);
      else begin
        spi_wait--;
        if (spi_wait == 0) spi_done = 1'b1;
      end
    end else begin
      spi_wait = 0;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(int v, int gap);
    sample_valid = 1'b1;
    sample_data  = 16'(v);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    while (!capture_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(capture_done), 32'd1);
  endtask

  // Reference model: trigger index and drained window from the raw sample list.
  function automatic bit qualifies(int v, int thr);
    int m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    return m >= thr;
  endfunction

  function automatic int find_trigger(int s[$]);
    int run = 0;
    for (int i = c_depth; i < s.size(); i++) begin
      if (qualifies(s[i], c_thr)) begin
        run++;
        if (run == c_valid) return i;
      end else begin
        run = 0;
      end
    end
    return -1;
  endfunction

  function automatic int window_errors(int s[$], int t);
    int errs = 0;
    if (drained.size() != c_depth + c_post) return 999;
    for (int i = 0; i < c_depth + c_post; i++)
      if (drained[i] !== 16'(s[t - c_depth + 1 + i])) errs++;
    return errs;
  endfunction

  function automatic int rand_sample();
    int r = int'($urandom_range(0, 9));
    if (r < 5) return int'($urandom_range(0, 62)) - 31;
    if (r < 9) return ($urandom_range(0, 1) != 0 ? 1 : -1) * int'($urandom_range(32, 2000));
    return -32768;
  endfunction

  int s[$];
  int t, k, wr0, rd0, roll0, clr0, spi0;
  int dir_vals[9] = '{3, 40, 40, 40, 10, 40, 40, 40, -40};

  initial begin
    rst = 1'b1; s_rst = 1'b1; enable = 1'b0; s_enable = 1'b0;
    sample_valid = 1'b0; sample_data = '0; force_full = 1'b0;
    tick(3);
    check("reset_outputs", 32'({fifo_wdata, fifo_write, fifo_read, fifo_clear,
                                data_avail, capture_done, overflow, state_dbg}), 32'd0);
    rst = 1'b0;
    tick(2);
    check("idle_held", 32'(state_dbg), 32'd0);

    // Directed capture: prefill, rolling trigger, post with enable dropped.
    s.delete(); drained.delete();
    wr0 = n_wr; roll0 = n_roll; rd0 = n_rd; clr0 = n_clr; spi0 = n_spi;
    enable = 1'b1;
    tick(1);
    check("clear_pulse", 32'(fifo_clear), 32'd1);
    check("prefill_state", 32'(state_dbg), 32'd1);
    for (int i = 0; i < c_depth; i++) begin
      s.push_back(5);
      send(5, i % 2);
      if (i == c_depth - 2) check("prefill_not_yet_armed", 32'(state_dbg), 32'd1);
    end
    check("armed_after_prefill", 32'(state_dbg), 32'd2);
    check("prefill_writes", 32'(n_wr - wr0), 32'(c_depth));
    check("prefill_no_reads", 32'(n_roll - roll0 + n_rd - rd0), 32'd0);
    check("prefill_one_clear", 32'(n_clr - clr0), 32'd1);
    for (int i = 0; i < 9; i++) begin
      s.push_back(dir_vals[i]);
      send(dir_vals[i], 0);
      if (i == 7) check("no_early_trigger", 32'(state_dbg), 32'd2);
    end
    check("trigger_to_post", 32'(state_dbg), 32'd3);
    tick(1);
    check("rolling_pops", 32'(n_roll - roll0), 32'd9);
    wr0 = n_wr;
    for (int i = 0; i < c_post; i++) begin
      s.push_back(100 + i);
      send(100 + i, (i == c_post - 1) ? 0 : i % 3);
      if (i == 4) enable = 1'b0;
    end
    check("post_to_settle", 32'(state_dbg), 32'd4);
    tick(1);
    check("settle_to_drain", 32'(state_dbg), 32'd5);
    check("drain_avail", 32'(data_avail), 32'd1);
    wait_done("directed_done");
    check("done_idle", 32'(state_dbg), 32'd0);
    check("post_writes", 32'(n_wr - wr0), 32'(c_post));
    check("drain_reads", 32'(n_rd - rd0), 32'(c_depth + c_post));
    check("spi_per_read", 32'(n_spi - spi0), 32'(n_rd - rd0));
    t = find_trigger(s);
    check("model_trigger_idx", 32'(t), 32'd18);
    check("directed_window", 32'(window_errors(s, t)), 32'd0);
    check("no_overflow", 32'(overflow), 32'd0);
    tick(5);
    check("idle_held_after_drain", 32'(state_dbg), 32'd0);
    check("avail_low_idle", 32'(data_avail), 32'd0);

    // Randomized captures.
    for (int it = 0; it < 5; it++) begin
      s.delete(); drained.delete();
      for (int i = 0; i < c_depth + 60; i++) s.push_back(rand_sample());
      for (int i = 0; i < c_valid; i++) s.push_back(1000 + i);
      for (int i = 0; i < c_post; i++) s.push_back(rand_sample());
      t = find_trigger(s);
      enable = 1'b1;
      tick(1);
      for (int i = 0; i <= t + c_post; i++) send(s[i], int'($urandom_range(0, 2)));
      enable = 1'b0;
      wait_done("rand_done");
      check("rand_window", 32'(window_errors(s, t)), 32'd0);
      check("rand_no_overflow", 32'(overflow), 32'd0);
      tick(2);
    end

    // Overflow: FIFO full during POST.
    drained.delete();
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < c_depth; i++) send(1, 0);
    for (int i = 0; i < c_valid; i++) send(200, 0);
    check("ovf_in_post", 32'(state_dbg), 32'd3);
    send(7, 0); send(8, 0);
    force_full = 1'b1;
    send(9, 0);
    check("ovf_no_write", 32'(fifo_write), 32'd0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_settle", 32'(state_dbg), 32'd4);
    force_full = 1'b0;
    enable = 1'b0;
    wait_done("ovf_done");
    check("ovf_drained", 32'(drained.size()), 32'(c_depth + 2));
    tick(3);
    check("ovf_sticky", 32'(overflow), 32'd1);
    enable = 1'b1;
    tick(1);
    check("ovf_restart_prefill", 32'(state_dbg), 32'd1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Drop enable while armed.
    for (int i = 0; i < c_depth; i++) send(2, 0);
    check("armed_before_drop", 32'(state_dbg), 32'd2);
    enable = 1'b0;
    tick(1);
    check("armed_drop_idle", 32'(state_dbg), 32'd0);

    // Reset during WAIT_SPI.
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < c_depth; i++) send(3, 0);
    for (int i = 0; i < c_valid; i++) send(-500, 0);
    for (int i = 0; i < c_post; i++) send(i, 0);
    k = 0;
    while (state_dbg != 3'd6 && k < 500) begin
      tick(1);
      k++;
    end
    check("reach_wait_spi", 32'(state_dbg), 32'd6);
    rst = 1'b1; enable = 1'b0;
    tick(1);
    check("rst_wait_spi_outputs", 32'({fifo_wdata, fifo_write, fifo_read, fifo_clear,
                                       data_avail, capture_done, overflow, state_dbg}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Saturation boundary on the full-scale instance.
    s_rst = 1'b0; s_enable = 1'b1;
    tick(1);
    check("sat_prefill", 32'(s_state), 32'd1);
    send(0, 0); send(0, 0);
    check("sat_armed", 32'(s_state), 32'd2);
    for (int i = 0; i < 4; i++) send(32766, 0);
    check("sat_32766_no_trigger", 32'(s_state), 32'd2);
    for (int i = 0; i < 3; i++) send(-32768, 0);
    check("sat_three_not_enough", 32'(s_state), 32'd2);
    send(-32768, 0);
    check("sat_trigger", 32'(s_state), 32'd3);
    s_enable = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
